// File: rtl/bp_sacc_mmio_initiator.sv
// Burst initiator for the uncached mem_fwd/mem_rev link: issues 8-byte requests, retires in-order responses.
// Optional response type/size checking driving err_o is enabled by defining SACC_INIT_RESP_CHECK_EN.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   e_idle  | waiting for a command; stale responses consumed and dropped
//   e_send  | issuing requests while credits remain
//   e_drain | all requests sent, waiting for remaining responses
//   e_done  | one-cycle completion pulse
module bp_sacc_mmio_initiator #(
    parameter int paddr_width_p       = 40,
    parameter int lce_id_width_p      = 8,
    parameter int acache_fill_width_p = 512,
    parameter int max_outstanding_p   = 4,
    parameter int len_width_p         = 10,
    localparam int mem_fwd_header_width_lp = 4 + paddr_width_p + 3 + lce_id_width_p,
    localparam int mem_rev_header_width_lp = mem_fwd_header_width_lp
) (
    input  logic                               clk_i,
    input  logic                               reset_n_i,
    input  logic [lce_id_width_p-1:0]          lce_id_i,
    input  logic                               cmd_v_i,
    output logic                               cmd_ready_and_o,
    input  logic                               cmd_w_i,
    input  logic [paddr_width_p-1:0]           cmd_addr_i,
    input  logic [len_width_p-1:0]             cmd_len_i,
    input  logic [63:0]                        wdata_i,
    input  logic                               wdata_v_i,
    output logic                               wdata_ready_and_o,
    output logic [63:0]                        rdata_o,
    output logic                               rdata_v_o,
    input  logic                               rdata_ready_and_i,
    output logic [mem_fwd_header_width_lp-1:0] mem_fwd_header_o,
    output logic [acache_fill_width_p-1:0]     mem_fwd_data_o,
    output logic                               mem_fwd_v_o,
    input  logic                               mem_fwd_ready_and_i,
    input  logic [mem_rev_header_width_lp-1:0] mem_rev_header_i,
    input  logic [acache_fill_width_p-1:0]     mem_rev_data_i,
    input  logic                               mem_rev_v_i,
    output logic                               mem_rev_ready_and_o,
    output logic                               busy_o,
    output logic                               done_o,
    output logic                               err_o
);

    // Header layout, LSB first: msg_type[3:0], addr, size[2:0], payload.lce_id
    localparam logic [3:0] e_bedrock_mem_uc_rd  = 4'd2;
    localparam logic [3:0] e_bedrock_mem_uc_wr  = 4'd3;
    localparam logic [2:0] e_bedrock_msg_size_8 = 3'd3;
    localparam int cred_width_lp = $clog2(max_outstanding_p + 1);

    typedef enum logic [1:0] {e_idle, e_send, e_drain, e_done} state_e;

    state_e                     state_q, state_d;
    logic                       w_q, w_d;
    logic [paddr_width_p-1:0]   base_q, base_d;
    logic [len_width_p-1:0]     len_q, len_d;
    logic [len_width_p-1:0]     sent_q, sent_d;
    logic [len_width_p-1:0]     recv_q, recv_d;
    logic [cred_width_lp-1:0]   credits_q, credits_d;

    logic                       in_burst;
    logic                       fwd_hs;
    logic                       rev_hs;
    logic                       stale_hs;
    logic [paddr_width_p-1:0]   req_addr;
    logic                       unused_rev_bits;

    assign in_burst = (state_q == e_send) || (state_q == e_drain);
    assign fwd_hs   = mem_fwd_v_o & mem_fwd_ready_and_i;
    assign rev_hs   = mem_rev_v_i & mem_rev_ready_and_o & in_burst;
    assign stale_hs = mem_rev_v_i & mem_rev_ready_and_o & (state_q == e_idle);
    assign req_addr = base_q + {{(paddr_width_p-len_width_p-3){1'b0}}, sent_q, 3'b000};
    assign unused_rev_bits = ^{mem_rev_header_i, mem_rev_data_i[acache_fill_width_p-1:64]};

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= e_idle;
            w_q       <= 1'b0;
            base_q    <= '0;
            len_q     <= '0;
            sent_q    <= '0;
            recv_q    <= '0;
            credits_q <= cred_width_lp'(max_outstanding_p);
        end else begin
            state_q   <= state_d;
            w_q       <= w_d;
            base_q    <= base_d;
            len_q     <= len_d;
            sent_q    <= sent_d;
            recv_q    <= recv_d;
            credits_q <= credits_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        w_d       = w_q;
        base_d    = base_q;
        len_d     = len_q;
        sent_d    = sent_q + len_width_p'(fwd_hs);
        recv_d    = recv_q + len_width_p'(rev_hs);
        credits_d = credits_q;
        if (fwd_hs && !rev_hs) begin
            credits_d = credits_q - cred_width_lp'(1);
        end else if (rev_hs && !fwd_hs) begin
            credits_d = credits_q + cred_width_lp'(1);
        end

        unique case (state_q)
            e_idle: begin
                if (cmd_v_i && cmd_ready_and_o) begin
                    w_d       = cmd_w_i;
                    base_d    = {cmd_addr_i[paddr_width_p-1:3], 3'b000};
                    len_d     = cmd_len_i;
                    sent_d    = '0;
                    recv_d    = '0;
                    credits_d = cred_width_lp'(max_outstanding_p);
                    state_d   = (cmd_len_i == '0) ? e_done : e_send;
                end
            end
            e_send: begin
                if (fwd_hs && (sent_d == len_q)) begin
                    state_d = e_drain;
                end
            end
            e_drain: begin
                if (recv_d == len_q) begin
                    state_d = e_done;
                end
            end
            e_done: begin
                state_d = e_idle;
            end
            default: state_d = e_idle;
        endcase
    end

    always_comb begin
        cmd_ready_and_o     = (state_q == e_idle) & reset_n_i;
        mem_fwd_v_o         = (state_q == e_send) && (credits_q != '0) && (!w_q || wdata_v_i);
        mem_fwd_header_o    = '0;
        mem_fwd_data_o      = '0;
        wdata_ready_and_o   = mem_fwd_v_o & mem_fwd_ready_and_i & w_q;
        mem_rev_ready_and_o = 1'b0;
        rdata_o             = '0;
        rdata_v_o           = 1'b0;
        busy_o              = (state_q != e_idle);
        done_o              = (state_q == e_done);

        if (state_q == e_send) begin
            mem_fwd_header_o = {lce_id_i, e_bedrock_msg_size_8, req_addr,
                                (w_q ? e_bedrock_mem_uc_wr : e_bedrock_mem_uc_rd)};
            if (w_q) begin
                mem_fwd_data_o = {{(acache_fill_width_p-64){1'b0}}, wdata_i};
            end
        end

        // Read data is a straight pass-through, so the responder sees our consumer's backpressure.
        if (state_q == e_idle) begin
            mem_rev_ready_and_o = reset_n_i;
        end else if (in_burst) begin
            if (w_q) begin
                mem_rev_ready_and_o = 1'b1;
            end else begin
                mem_rev_ready_and_o = rdata_ready_and_i;
                rdata_v_o           = mem_rev_v_i;
                rdata_o             = mem_rev_data_i[63:0];
            end
        end
    end

`ifdef SACC_INIT_RESP_CHECK_EN
    logic       err_q, err_d;
    logic [3:0] rev_type;
    logic [2:0] rev_size;
    logic       rev_bad;

    assign rev_type = mem_rev_header_i[3:0];
    assign rev_size = mem_rev_header_i[4+paddr_width_p +: 3];
    assign rev_bad  = (rev_type != (w_q ? e_bedrock_mem_uc_wr : e_bedrock_mem_uc_rd))
                    || (rev_size != e_bedrock_msg_size_8);
    assign err_d    = err_q | stale_hs | (rev_hs & rev_bad);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    logic unused_stale;
    assign unused_stale = stale_hs;
    assign err_o        = 1'b0;
`endif

endmodule

// File: tb/tb_bp_sacc_mmio_initiator.sv
// Directed bench for bp_sacc_mmio_initiator with an in-order behavioural responder.
module tb_bp_sacc_mmio_initiator;

    localparam int PA = 40;
    localparam int LW = 8;
    localparam int FW = 512;
    localparam int HW = 4 + PA + 3 + LW;
    localparam logic [3:0] UC_RD = 4'd2;
    localparam logic [3:0] UC_WR = 4'd3;
    localparam logic [2:0] SZ8   = 3'd3;
    localparam logic [7:0] LCE   = 8'h5A;
`ifdef SACC_INIT_RESP_CHECK_EN
    localparam logic EXP_STALE_ERR = 1'b1;
`else
    localparam logic EXP_STALE_ERR = 1'b0;
`endif

    logic           clk_i = 1'b0;
    logic           reset_n_i = 1'b0;
    logic [LW-1:0]  lce_id_i = LCE;
    logic           cmd_v_i = 1'b0;
    logic           cmd_ready_and_o;
    logic           cmd_w_i = 1'b0;
    logic [PA-1:0]  cmd_addr_i = '0;
    logic [9:0]     cmd_len_i = '0;
    logic [63:0]    wdata_i = '0;
    logic           wdata_v_i = 1'b0;
    logic           wdata_ready_and_o;
    logic [63:0]    rdata_o;
    logic           rdata_v_o;
    logic           rdata_ready_and_i = 1'b1;
    logic [HW-1:0]  mem_fwd_header_o;
    logic [FW-1:0]  mem_fwd_data_o;
    logic           mem_fwd_v_o;
    logic           mem_fwd_ready_and_i = 1'b1;
    logic [HW-1:0]  mem_rev_header_i = '0;
    logic [FW-1:0]  mem_rev_data_i = '0;
    logic           mem_rev_v_i = 1'b0;
    logic           mem_rev_ready_and_o;
    logic           busy_o;
    logic           done_o;
    logic           err_o;

    bp_sacc_mmio_initiator dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .lce_id_i(lce_id_i),
        .cmd_v_i(cmd_v_i), .cmd_ready_and_o(cmd_ready_and_o), .cmd_w_i(cmd_w_i),
        .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
        .wdata_i(wdata_i), .wdata_v_i(wdata_v_i), .wdata_ready_and_o(wdata_ready_and_o),
        .rdata_o(rdata_o), .rdata_v_o(rdata_v_o), .rdata_ready_and_i(rdata_ready_and_i),
        .mem_fwd_header_o(mem_fwd_header_o), .mem_fwd_data_o(mem_fwd_data_o),
        .mem_fwd_v_o(mem_fwd_v_o), .mem_fwd_ready_and_i(mem_fwd_ready_and_i),
        .mem_rev_header_i(mem_rev_header_i), .mem_rev_data_i(mem_rev_data_i),
        .mem_rev_v_i(mem_rev_v_i), .mem_rev_ready_and_o(mem_rev_ready_and_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;

    // Responder and capture state
    logic [3:0]    pend_t[$];
    logic [PA-1:0] pend_a[$];
    logic [63:0]   pend_d[$];
    logic [63:0]   rd_data[$];
    logic [63:0]   wq[$];
    logic [3:0]    cap_t[$];
    logic [PA-1:0] cap_a[$];
    logic [63:0]   cap_d[$];
    logic [63:0]   rcv[$];
    logic          hold = 1'b0;
    logic          cmd_pend = 1'b0;
    logic          rdy_req = 1'b1;
    logic          cur_w = 1'b0;
    logic          last_fwd_v, last_done, last_busy;
    int            fwd_cnt, done_cnt, rdv_cnt, bp_bad, hdr_bad, wr_bad;

    task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        cap_t.delete(); cap_a.delete(); cap_d.delete(); rcv.delete();
        fwd_cnt = 0; done_cnt = 0; rdv_cnt = 0; bp_bad = 0; hdr_bad = 0; wr_bad = 0;
    endtask

    // One clock cycle: drive at negedge, observe after settling, commit at posedge.
    task automatic step();
        @(negedge clk_i);
        cmd_v_i = cmd_pend;
        rdata_ready_and_i = rdy_req;
        if (pend_t.size() > 0 && !hold) begin
            mem_rev_v_i      = 1'b1;
            mem_rev_header_i = {LCE, SZ8, pend_a[0], pend_t[0]};
            mem_rev_data_i   = {{(FW-64){1'b0}}, pend_d[0]};
        end else begin
            mem_rev_v_i      = 1'b0;
            mem_rev_header_i = '0;
            mem_rev_data_i   = '0;
        end
        wdata_v_i = (wq.size() > 0);
        wdata_i   = (wq.size() > 0) ? wq[0] : 64'h0;
        #1;
        last_fwd_v = mem_fwd_v_o;
        last_done  = done_o;
        last_busy  = busy_o;
        if (done_o) done_cnt++;
        if (rdata_v_o) rdv_cnt++;
        if (!rdy_req && busy_o && !cur_w && mem_rev_ready_and_o) bp_bad++;
        if (cmd_v_i && cmd_ready_and_o) cmd_pend = 1'b0;
        if (mem_fwd_v_o && mem_fwd_ready_and_i) begin
            logic [3:0] t;
            t = mem_fwd_header_o[3:0];
            fwd_cnt++;
            if (mem_fwd_header_o[4+PA +: 3] != SZ8 || mem_fwd_header_o[7+PA +: LW] != LCE
                || mem_fwd_data_o[FW-1:64] != '0) hdr_bad++;
            cap_t.push_back(t);
            cap_a.push_back(mem_fwd_header_o[4 +: PA]);
            cap_d.push_back(mem_fwd_data_o[63:0]);
            pend_t.push_back(t);
            pend_a.push_back(mem_fwd_header_o[4 +: PA]);
            if (t == UC_RD && rd_data.size() > 0) pend_d.push_back(rd_data.pop_front());
            else pend_d.push_back(64'h0);
            if (t == UC_WR) begin
                if (!wdata_ready_and_o) wr_bad++;
                if (wq.size() > 0) void'(wq.pop_front());
            end
        end
        if (mem_rev_v_i && mem_rev_ready_and_o) begin
            if (rdata_v_o) rcv.push_back(rdata_o);
            void'(pend_t.pop_front());
            void'(pend_a.pop_front());
            void'(pend_d.pop_front());
        end
        @(posedge clk_i);
    endtask

    task automatic start_cmd(input logic w, input logic [PA-1:0] a, input logic [9:0] len);
        cur_w      = w;
        cmd_w_i    = w;
        cmd_addr_i = a;
        cmd_len_i  = len;
        cmd_pend   = 1'b1;
        step();
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            step();
            n++;
        end
        if (done_cnt == 0) chk_val({tag, "_timeout"}, 64'd0, 64'd1);
        step();
        step();
    endtask

    initial begin
        clear_logs();
        // Reset held
        repeat (2) @(negedge clk_i);
        #1;
        chk_val("rst_cmd_ready", cmd_ready_and_o, 0);
        chk_val("rst_outs", {mem_fwd_v_o, mem_rev_ready_and_o, rdata_v_o, busy_o, done_o, err_o, wdata_ready_and_o}, 0);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        #1;
        chk_val("rel_cmd_ready", cmd_ready_and_o, 1);

        // Write burst, len 4
        clear_logs();
        wq = '{64'hA, 64'hB, 64'hC, 64'hD};
        start_cmd(1'b1, 40'h0020_0008, 10'd4);
        wait_done("wr4", 60);
        chk_val("wr4_cnt", fwd_cnt, 4);
        for (int i = 0; i < 4 && i < cap_a.size(); i++) begin
            chk_val($sformatf("wr4_addr%0d", i), cap_a[i], 40'h0020_0008 + 40'(8*i));
            chk_val($sformatf("wr4_data%0d", i), cap_d[i], 64'hA + 64'(i));
            chk_val($sformatf("wr4_type%0d", i), cap_t[i], UC_WR);
        end
        chk_val("wr4_hdr_fields", hdr_bad, 0);
        chk_val("wr4_wready", wr_bad, 0);
        chk_val("wr4_done_pulses", done_cnt, 1);
        chk_val("wr4_rdata_v", rdv_cnt, 0);
        chk_val("wr4_idle", last_busy, 0);

        // Read burst, len 3
        clear_logs();
        rd_data = '{64'h11, 64'h22, 64'h33};
        start_cmd(1'b0, 40'h0020_0000, 10'd3);
        wait_done("rd3", 60);
        chk_val("rd3_cnt", rcv.size(), 3);
        for (int i = 0; i < 3 && i < rcv.size(); i++)
            chk_val($sformatf("rd3_data%0d", i), rcv[i], 64'h11 * 64'(i+1));
        chk_val("rd3_type", (cap_t.size() > 0) ? cap_t[0] : 4'hF, UC_RD);
        chk_val("rd3_addr2", (cap_a.size() > 2) ? cap_a[2] : '1, 40'h0020_0010);
        chk_val("rd3_done_pulses", done_cnt, 1);

        // Credit limit: responses withheld
        clear_logs();
        hold = 1'b1;
        for (int i = 0; i < 8; i++) rd_data.push_back(64'h100 + 64'(i));
        start_cmd(1'b0, 40'h0030_0000, 10'd8);
        repeat (10) step();
        chk_val("cred_fwd_cnt", fwd_cnt, 4);
        chk_val("cred_fwd_v_stall", last_fwd_v, 0);
        hold = 1'b0;
        wait_done("cred", 80);
        chk_val("cred_rcv_cnt", rcv.size(), 8);
        for (int i = 0; i < 8 && i < rcv.size(); i++)
            chk_val($sformatf("cred_data%0d", i), rcv[i], 64'h100 + 64'(i));

        // Read-side backpressure for 5 cycles
        clear_logs();
        for (int i = 0; i < 6; i++) rd_data.push_back(64'h200 + 64'(i));
        start_cmd(1'b0, 40'h0040_0000, 10'd6);
        repeat (3) step();
        rdy_req = 1'b0;
        repeat (5) step();
        rdy_req = 1'b1;
        wait_done("bp", 60);
        chk_val("bp_rev_ready_low", bp_bad, 0);
        chk_val("bp_rcv_cnt", rcv.size(), 6);
        for (int i = 0; i < 6 && i < rcv.size(); i++)
            chk_val($sformatf("bp_data%0d", i), rcv[i], 64'h200 + 64'(i));

        // Zero-length command: DONE the cycle after accept, no traffic
        clear_logs();
        start_cmd(1'b1, 40'h0050_0000, 10'd0);
        step();
        chk_val("len0_done", last_done, 1);
        step();
        chk_val("len0_done_pulses", done_cnt, 1);
        chk_val("len0_fwd", fwd_cnt, 0);
        chk_val("len0_idle", last_busy, 0);

        // Address wrap
        clear_logs();
        wq = '{64'h77, 64'h88};
        start_cmd(1'b1, 40'hFF_FFFF_FFF8, 10'd2);
        wait_done("wrap", 40);
        chk_val("wrap_addr0", (cap_a.size() > 0) ? cap_a[0] : '0, 40'hFF_FFFF_FFF8);
        chk_val("wrap_addr1", (cap_a.size() > 1) ? cap_a[1] : '1, 40'h0);
        chk_val("err_clean", err_o, 0);

        // Reset after 2 of 4 writes, then stale responses in IDLE
        clear_logs();
        hold = 1'b1;
        wq = '{64'h1, 64'h2};
        start_cmd(1'b1, 40'h0000_1000, 10'd4);
        for (int i = 0; i < 20 && fwd_cnt < 2; i++) step();
        step();
        chk_val("mid_fwd_cnt", fwd_cnt, 2);
        @(negedge clk_i);
        reset_n_i = 1'b0;
        wq.delete();
        wdata_v_i = 1'b0;
        #1;
        chk_val("mid_rst_outs", {mem_fwd_v_o, busy_o, done_o, cmd_ready_and_o, mem_rev_ready_and_o, wdata_ready_and_o}, 0);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        @(posedge clk_i);
        hold = 1'b0;
        repeat (6) step();
        chk_val("stale_consumed", pend_t.size(), 0);
        chk_val("stale_no_done", done_cnt, 0);
        chk_val("stale_err", err_o, EXP_STALE_ERR);
        chk_val("stale_idle", last_busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "time limit");
    end

endmodule
